// File: rtl/packet_rx_pkg.sv
// packet_rx_pkg: shared PID codes, PID-class decode, CRC polynomials/residuals and FSM encodings
// for the USB full-speed packet receiver.
package packet_rx_pkg;

  localparam int unsigned PID_W      = 4;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LEN_W      = 14;
  localparam int unsigned CRC5_W     = 5;
  localparam int unsigned CRC16_W    = 16;
  localparam int unsigned TOKEN_LEN  = 16;
  localparam int unsigned DATA_MIN   = 16;

  // Token PIDs
  localparam logic [PID_W-1:0] PID_OUT   = 4'b0001;
  localparam logic [PID_W-1:0] PID_IN    = 4'b1001;
  localparam logic [PID_W-1:0] PID_SOF   = 4'b0101;
  localparam logic [PID_W-1:0] PID_SETUP = 4'b1101;
  // Data PIDs
  localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;
  localparam logic [PID_W-1:0] PID_DATA1 = 4'b1011;
  localparam logic [PID_W-1:0] PID_DATA2 = 4'b0111;
  localparam logic [PID_W-1:0] PID_MDATA = 4'b1111;
  // Handshake PIDs
  localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
  localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;
  localparam logic [PID_W-1:0] PID_STALL = 4'b1110;
  localparam logic [PID_W-1:0] PID_NYET  = 4'b0110;

  localparam logic [CRC5_W-1:0]  CRC5_POLY      = 5'b00101;
  localparam logic [CRC5_W-1:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [CRC16_W-1:0] CRC16_POLY     = 16'h8005;
  localparam logic [CRC16_W-1:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PID   = 3'd1,
    ST_TOKEN = 3'd2,
    ST_DATA  = 3'd3,
    ST_HSHK  = 3'd4,
    ST_DONE  = 3'd5
  } rx_state_e;

  typedef enum logic [1:0] {
    CLS_TOKEN = 2'd0,
    CLS_DATA  = 2'd1,
    CLS_HSHK  = 2'd2
  } pid_class_e;

  // Classify a PID; anything that is not a token or data PID carries no payload.
  function automatic pid_class_e pid_class(input logic [PID_W-1:0] pid);
    pid_class_e cls;
    cls = CLS_HSHK;
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP:       cls = CLS_TOKEN;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: cls = CLS_DATA;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:     cls = CLS_HSHK;
      default:                                   cls = CLS_HSHK;
    endcase
    return cls;
  endfunction

  // Upper nibble must be the complement of the lower nibble.
  function automatic logic pid_check(input logic [2*PID_W-1:0] pid_byte);
    return pid_byte[2*PID_W-1:PID_W] == ~pid_byte[PID_W-1:0];
  endfunction

  function automatic pid_state_dummy_unused_guard(input logic a);
    return a;
  endfunction

  // Next FSM state once the PID class is known.
  function automatic rx_state_e class_state(input pid_class_e cls);
    rx_state_e st;
    case (cls)
      CLS_TOKEN: st = ST_TOKEN;
      CLS_DATA:  st = ST_DATA;
      default:   st = ST_HSHK;
    endcase
    return st;
  endfunction

  // One serial CRC5 step, bits presented LSB first.
  function automatic logic [CRC5_W-1:0] crc5_step(input logic [CRC5_W-1:0] crc, input logic b);
    logic [CRC5_W-1:0] sh;
    sh = {crc[CRC5_W-2:0], 1'b0};
    return (b ^ crc[CRC5_W-1]) ? (sh ^ CRC5_POLY) : sh;
  endfunction

  // One serial CRC16 step, bits presented LSB first.
  function automatic logic [CRC16_W-1:0] crc16_step(input logic [CRC16_W-1:0] crc, input logic b);
    logic [CRC16_W-1:0] sh;
    sh = {crc[CRC16_W-2:0], 1'b0};
    return (b ^ crc[CRC16_W-1]) ? (sh ^ CRC16_POLY) : sh;
  endfunction

endpackage

// File: rtl/packet_rx_crc.sv
// packet_rx_crc: serial CRC5 and CRC16 over the post-PID bit stream.
// Match outputs reflect the register value including the bit presented this cycle.
module packet_rx_crc
  import packet_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic crc5_ok_c_o,
  output logic crc16_ok_c_o
);

  logic [CRC5_W-1:0]  crc5_q,  crc5_d;
  logic [CRC16_W-1:0] crc16_q, crc16_d;

  // Next CRC value: preset on clear, shifted on each enabled bit.
  always_comb begin
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    if (clr_i) begin
      crc5_d  = '1;
      crc16_d = '1;
    end else if (en_i) begin
      crc5_d  = crc5_step(crc5_q, bit_i);
      crc16_d = crc16_step(crc16_q, bit_i);
    end
  end

  // CRC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc5_q  <= '0;
      crc16_q <= '0;
    end else begin
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  assign crc5_ok_c_o  = (crc5_d == CRC5_RESIDUAL);
  assign crc16_ok_c_o = (crc16_d == CRC16_RESIDUAL);

endmodule

// File: rtl/packet_rx.sv
// packet_rx: USB full-speed packet receiver, bit-to-packet layer.
// Build macro PACKET_RX_CRC_CHECK_EN: when defined, CRC5/CRC16 residuals gate rx_packet_valid;
// otherwise no CRC logic is built and valid depends on PID and length only.
module packet_rx
  import packet_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_start,
  input  logic              rx_finish,
  input  logic              rx_status,
  input  logic              rx_bit,
  output logic [PID_W-1:0]  rx_packet_pid,
  output logic              rx_packet_pid_valid,
  output logic [ADDR_W-1:0] rx_packet_addr,
  output logic [BYTE_W-1:0] rx_packet_byte,
  output logic              rx_packet_byte_en,
  output logic              rx_packet_valid,
  output logic              rx_packet_fin
);

  rx_state_e         state_q;
  pid_class_e        cls_q;
  logic [2:0]        pid_cnt_q;
  logic [6:0]        pid_sr_q;
  logic [LEN_W-1:0]  len_q;
  logic [6:0]        byte_sr_q;
  logic [BYTE_W-1:0] hold0_q, hold1_q;
  logic [1:0]        held_q;
  logic [PID_W-1:0]  pid_q;
  logic              pid_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] byte_q;
  logic              byte_en_q;
  logic              valid_q;
  logic              fin_q;

  logic              active_c, bit_en_c, pid_bit_c, body_bit_c, pid_last_c;
  logic              len_sat_c, byte_done_c, pid_done_c, pid_valid_c;
  logic              len_ok_c, crc_ok_c, valid_c;
  logic [7:0]        pid_full_c;
  logic [BYTE_W-1:0] byte_full_c;
  logic [LEN_W-1:0]  len_c;
  pid_class_e        cls_c;

`ifdef PACKET_RX_CRC_CHECK_EN
  logic crc5_ok_c, crc16_ok_c;

  packet_rx_crc u_crc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (rx_start),
    .en_i         (body_bit_c),
    .bit_i        (rx_bit),
    .crc5_ok_c_o  (crc5_ok_c),
    .crc16_ok_c_o (crc16_ok_c)
  );
`endif

  // Bit qualification and the packet verdict as it stands after this cycle's bit.
  always_comb begin
    active_c    = (state_q == ST_PID) || (state_q == ST_TOKEN) ||
                  (state_q == ST_DATA) || (state_q == ST_HSHK);
    bit_en_c    = rx_status & ~rx_start & active_c;
    pid_bit_c   = bit_en_c & (state_q == ST_PID);
    body_bit_c  = bit_en_c & (state_q != ST_PID);
    pid_full_c  = {rx_bit, pid_sr_q};
    pid_last_c  = pid_bit_c & (pid_cnt_q == 3'd7);
    len_sat_c   = &len_q;
    len_c       = len_q;
    if (body_bit_c && !len_sat_c) begin
      len_c = len_q + LEN_W'(1);
    end
    byte_full_c = {rx_bit, byte_sr_q};
    byte_done_c = body_bit_c & ~len_sat_c & (state_q == ST_DATA) & (len_q[2:0] == 3'd7);
    pid_done_c  = pid_last_c | (state_q != ST_PID);
    pid_valid_c = pid_last_c ? pid_check(pid_full_c) : pid_valid_q;
    cls_c       = pid_last_c ? pid_class(pid_full_c[3:0]) : cls_q;
    len_ok_c    = 1'b0;
    case (cls_c)
      CLS_TOKEN: len_ok_c = (len_c == LEN_W'(TOKEN_LEN));
      CLS_DATA:  len_ok_c = (len_c[2:0] == 3'd0) && (len_c >= LEN_W'(DATA_MIN));
      default:   len_ok_c = (len_c == '0);
    endcase
    crc_ok_c = 1'b1;
`ifdef PACKET_RX_CRC_CHECK_EN
    case (cls_c)
      CLS_TOKEN: crc_ok_c = crc5_ok_c;
      CLS_DATA:  crc_ok_c = crc16_ok_c;
      default:   crc_ok_c = 1'b1;
    endcase
`endif
    valid_c = pid_done_c & pid_valid_c & len_ok_c & crc_ok_c;
  end

  // Receiver FSM, field capture, byte holding buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cls_q       <= CLS_TOKEN;
      pid_cnt_q   <= '0;
      pid_sr_q    <= '0;
      len_q       <= '0;
      byte_sr_q   <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
      held_q      <= '0;
      pid_q       <= '0;
      pid_valid_q <= 1'b0;
      addr_q      <= '0;
      byte_q      <= '0;
      byte_en_q   <= 1'b0;
      valid_q     <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      fin_q     <= 1'b0;
      byte_en_q <= 1'b0;
      if (rx_start) begin
        state_q     <= ST_PID;
        cls_q       <= CLS_TOKEN;
        pid_cnt_q   <= '0;
        pid_sr_q    <= '0;
        len_q       <= '0;
        byte_sr_q   <= '0;
        held_q      <= '0;
        pid_q       <= '0;
        pid_valid_q <= 1'b0;
        addr_q      <= '0;
        valid_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_DONE: state_q <= ST_IDLE;
          default: begin
            if (pid_bit_c) begin
              pid_sr_q  <= pid_full_c[7:1];
              pid_cnt_q <= 3'(pid_cnt_q + 3'd1);
              if (pid_last_c) begin
                pid_q       <= pid_full_c[3:0];
                pid_valid_q <= pid_valid_c;
                cls_q       <= cls_c;
                state_q     <= class_state(cls_c);
              end
            end
            if (body_bit_c) begin
              len_q <= len_c;
              if ((state_q == ST_TOKEN) && (len_q < LEN_W'(ADDR_W))) begin
                addr_q[len_q[3:0]] <= rx_bit;
              end
              if ((state_q == ST_DATA) && !len_sat_c) begin
                byte_sr_q <= byte_full_c[7:1];
              end
            end
            // Two completed bytes are always withheld so the CRC16 field is never emitted.
            if (byte_done_c) begin
              case (held_q)
                2'd0: begin
                  hold0_q <= byte_full_c;
                  held_q  <= 2'd1;
                end
                2'd1: begin
                  hold1_q <= byte_full_c;
                  held_q  <= 2'd2;
                end
                default: begin
                  byte_q    <= hold0_q;
                  byte_en_q <= 1'b1;
                  hold0_q   <= hold1_q;
                  hold1_q   <= byte_full_c;
                end
              endcase
            end
            if (rx_finish) begin
              state_q <= ST_DONE;
              fin_q   <= 1'b1;
              valid_q <= valid_c;
            end
          end
        endcase
      end
    end
  end

  assign rx_packet_pid       = pid_q;
  assign rx_packet_pid_valid = pid_valid_q;
  assign rx_packet_addr      = addr_q;
  assign rx_packet_byte      = byte_q;
  assign rx_packet_byte_en   = byte_en_q;
  assign rx_packet_valid     = valid_q;
  assign rx_packet_fin       = fin_q;

endmodule

// File: tb/tb_packet_rx.sv
// tb_packet_rx: bench for packet_rx. Packets are built from bit vectors with CRC fields
// generated by a transmitter-side model; expected packets and bytes go into scoreboard queues.
module tb_packet_rx;

`ifdef PACKET_RX_CRC_CHECK_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_start = 1'b0;
  logic        rx_finish = 1'b0;
  logic        rx_status = 1'b0;
  logic        rx_bit = 1'b0;
  logic [3:0]  rx_packet_pid;
  logic        rx_packet_pid_valid;
  logic [10:0] rx_packet_addr;
  logic [7:0]  rx_packet_byte;
  logic        rx_packet_byte_en;
  logic        rx_packet_valid;
  logic        rx_packet_fin;

  always #5 clk = ~clk;

  packet_rx dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_start            (rx_start),
    .rx_finish           (rx_finish),
    .rx_status           (rx_status),
    .rx_bit              (rx_bit),
    .rx_packet_pid       (rx_packet_pid),
    .rx_packet_pid_valid (rx_packet_pid_valid),
    .rx_packet_addr      (rx_packet_addr),
    .rx_packet_byte      (rx_packet_byte),
    .rx_packet_byte_en   (rx_packet_byte_en),
    .rx_packet_valid     (rx_packet_valid),
    .rx_packet_fin       (rx_packet_fin)
  );

  typedef struct packed {
    logic [3:0]  pid;
    logic        pid_valid;
    logic        valid;
    logic        chk_addr;
    logic [10:0] addr;
  } pkt_exp_t;

  typedef struct {
    logic [127:0] bits;
    int           nbits;
    logic         fin_with_last;
    pkt_exp_t     exp;
    int           nbytes;
    logic [23:0]  bytes;
  } vec_t;

  int        checks = 0;
  int        failures = 0;
  int        fin_count = 0;
  pkt_exp_t  exp_pkts[$];
  logic [7:0] exp_bytes[$];
  vec_t      vecs[$];
  logic [127:0] wb;
  int        wn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: compare every byte strobe and every fin pulse against the queues.
  pkt_exp_t mon_e;
  logic [7:0] mon_b;
  always @(negedge clk) begin
    if (rst_n && rx_packet_byte_en) begin
      if (exp_bytes.size() == 0) begin
        check("unexpected_byte_en", 32'(rx_packet_byte), 32'hFFFF_FFFF);
      end else begin
        mon_b = exp_bytes.pop_front();
        check("byte", 32'(rx_packet_byte), 32'(mon_b));
      end
    end
    if (rst_n && rx_packet_fin) begin
      fin_count++;
      if (exp_pkts.size() == 0) begin
        check("unexpected_fin", 32'(1), 32'(0));
      end else begin
        mon_e = exp_pkts.pop_front();
        check("pid", 32'(rx_packet_pid), 32'(mon_e.pid));
        check("pid_valid", 32'(rx_packet_pid_valid), 32'(mon_e.pid_valid));
        check("valid", 32'(rx_packet_valid), 32'(mon_e.valid));
        if (mon_e.chk_addr) check("addr", 32'(rx_packet_addr), 32'(mon_e.addr));
        if (exp_bytes.size() != 0) check("bytes_left_at_fin", 32'(exp_bytes.size()), 32'(0));
      end
    end
  end

  task automatic put(input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      wb[wn] = v[k];
      wn++;
    end
  endtask

  function automatic logic [4:0] crc5_of(input logic [10:0] d);
    logic [4:0] c;
    c = '1;
    for (int k = 0; k < 11; k++) begin
      if (d[k] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_of(input logic [23:0] d, input int n);
    logic [15:0] c;
    c = '1;
    for (int k = 0; k < n; k++) begin
      if (d[k] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Transmitted CRC field: inverted remainder, MSB of the shift register first.
  task automatic put_crc5(input logic [10:0] d, input logic flip);
    logic [4:0] c;
    logic b;
    c = crc5_of(d);
    for (int k = 4; k >= 0; k--) begin
      b = ~c[k];
      if (flip && k == 0) b = ~b;
      put(32'(b), 1);
    end
  endtask

  task automatic put_crc16(input logic [23:0] d, input int n, input logic flip);
    logic [15:0] c;
    logic b;
    c = crc16_of(d, n);
    for (int k = 15; k >= 0; k--) begin
      b = ~c[k];
      if (flip && k == 3) b = ~b;
      put(32'(b), 1);
    end
  endtask

  task automatic begin_vec();
    wb = '0;
    wn = 0;
  endtask

  task automatic add_vec(input logic fwl, input logic [3:0] pid, input logic pv, input logic valid,
                         input logic chk, input logic [10:0] addr, input int nbytes,
                         input logic [23:0] bytes);
    vec_t v;
    v.bits = wb;
    v.nbits = wn;
    v.fin_with_last = fwl;
    v.exp = '{pid: pid, pid_valid: pv, valid: valid, chk_addr: chk, addr: addr};
    v.nbytes = nbytes;
    v.bytes = bytes;
    vecs.push_back(v);
  endtask

  task automatic start_pkt();
    rx_start = 1'b1;
    rx_status = 1'b1;  // bits offered during start must be ignored
    rx_bit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rx_start = 1'b0;
    rx_status = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rx_status = 1'b1;
    rx_bit = b;
    @(posedge clk);
    #1;
    rx_status = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 12 && (exp_pkts.size() != 0 || exp_bytes.size() != 0); t++) begin
      @(posedge clk);
      #1;
    end
    if (exp_pkts.size() != 0 || exp_bytes.size() != 0) begin
      check(name, 32'(exp_pkts.size() + exp_bytes.size()), 32'(0));
      exp_pkts.delete();
      exp_bytes.delete();
    end
  endtask

  task automatic apply(input int i);
    vec_t v;
    logic [23:0] bb;
    v = vecs[i];
    bb = v.bytes;
    start_pkt();
    exp_pkts.push_back(v.exp);
    for (int j = 0; j < v.nbytes; j++) exp_bytes.push_back(bb[8*j +: 8]);
    for (int k = 0; k < v.nbits; k++) begin
      rx_status = 1'b1;
      rx_bit = v.bits[k];
      rx_finish = v.fin_with_last && (k == v.nbits - 1);
      @(posedge clk);
      #1;
      rx_status = 1'b0;
      rx_finish = 1'b0;
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk);
        #1;
      end
    end
    if (!v.fin_with_last) begin
      rx_finish = 1'b1;
      @(posedge clk);
      #1;
      rx_finish = 1'b0;
    end
    drain($sformatf("vec%0d_timeout", i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx_mdata;
    int fc;
    logic [7:0] ack_bits;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pid", 32'(rx_packet_pid), 32'(0));
    check("rst_pid_valid", 32'(rx_packet_pid_valid), 32'(0));
    check("rst_addr", 32'(rx_packet_addr), 32'(0));
    check("rst_byte_en", 32'(rx_packet_byte_en), 32'(0));
    check("rst_valid", 32'(rx_packet_valid), 32'(0));
    check("rst_fin", 32'(rx_packet_fin), 32'(0));
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Packet table
    begin_vec(); put(32'hE1, 8); put(32'h567, 11); put_crc5(11'h567, 1'b0);
    add_vec(1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 11'h567, 0, 24'h0);                 // OUT good
    begin_vec(); put(32'hE1, 8); put(32'h567, 11); put_crc5(11'h567, 1'b1);
    add_vec(1'b0, 4'h1, 1'b1, ~CRC_ON, 1'b1, 11'h567, 0, 24'h0);             // OUT bad CRC
    begin_vec(); put(32'hD2, 8);
    add_vec(1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 11'h0, 0, 24'h0);                   // ACK
    idx_mdata = vecs.size();
    begin_vec(); put(32'h0F, 8); put(32'h8A6567, 24); put_crc16(24'h8A6567, 24, 1'b0);
    add_vec(1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 11'h0, 3, 24'h8A6567);             // MDATA good
    begin_vec(); put(32'h0F, 8); put(32'h8A6567, 24); put_crc16(24'h8A6567, 24, 1'b1);
    add_vec(1'b0, 4'hF, 1'b1, ~CRC_ON, 1'b0, 11'h0, 3, 24'h8A6567);          // MDATA bad CRC
    begin_vec(); put(32'h00, 8);
    add_vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 11'h0, 0, 24'h0);                   // bad PID check
    begin_vec(); put(32'hC3, 8); put(32'hABCDE, 20);
    add_vec(1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 11'h0, 0, 24'h0);                   // 20-bit data
    begin_vec(); put(32'hE1, 8); put(32'h567, 11); put_crc5(11'h567, 1'b0); put(32'h1, 1);
    add_vec(1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 11'h567, 0, 24'h0);                 // token 17 bits
    begin_vec(); put(32'hE1, 8); put(32'h567, 11); put_crc5(11'h567, 1'b0); wn = wn - 1;
    add_vec(1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 11'h567, 0, 24'h0);                 // token 15 bits
    begin_vec(); put(32'hE1, 4);
    add_vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 11'h0, 0, 24'h0);                   // finish in PID
    begin_vec(); put(32'h4B, 8); put_crc16(24'h0, 0, 1'b0);
    add_vec(1'b0, 4'hB, 1'b1, 1'b1, 1'b0, 11'h0, 0, 24'h0);                   // zero-length DATA1
    begin_vec(); put(32'h5A, 8); put(32'h0, 1);
    add_vec(1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 11'h0, 0, 24'h0);                   // NAK + extra bit
    begin_vec(); put(32'hD2, 8);
    add_vec(1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 11'h0, 0, 24'h0);                   // ACK, finish with last bit
    begin_vec(); put(32'h69, 8); put(32'h0, 11); put_crc5(11'h0, 1'b0);
    add_vec(1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 11'h0, 0, 24'h0);                   // IN, finish with last bit
    begin_vec(); put(32'h2D, 8); put(32'h1000, 16);
    add_vec(1'b0, 4'hD, 1'b1, 1'b1, 1'b1, 11'h0, 0, 24'h0);                   // SETUP addr0: 2D 00 10
    begin_vec(); put(32'hC3, 8); put(32'h3412, 16); put_crc16(24'h3412, 16, 1'b0);
    add_vec(1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 11'h0, 2, 24'h003412);             // DATA0, finish with last bit

    for (int i = 0; i < vecs.size(); i++) apply(i);

    // PID timing: pid/pid_valid appear one cycle after the 8th bit
    ack_bits = 8'hD2;
    start_pkt();
    for (int k = 0; k < 8; k++) begin
      send_bit(ack_bits[k]);
      @(negedge clk);
      if (k == 6) check("pid_valid_before_8th", 32'(rx_packet_pid_valid), 32'(0));
      if (k == 7) begin
        check("pid_after_8th", 32'(rx_packet_pid), 32'(2));
        check("pid_valid_after_8th", 32'(rx_packet_pid_valid), 32'(1));
      end
      #1;
    end

    // Restart mid data packet: held bytes and fields must be discarded
    start_pkt();
    @(negedge clk);
    check("restart_pid", 32'(rx_packet_pid), 32'(0));
    check("restart_pid_valid", 32'(rx_packet_pid_valid), 32'(0));
    #1;
    begin_vec(); put(32'h0F, 8); put(32'hFFFFF, 20);
    for (int k = 0; k < wn; k++) send_bit(wb[k]);
    apply(idx_mdata);

    // Reset in the middle of a token: immediate abort, no fin
    fc = fin_count;
    start_pkt();
    begin_vec(); put(32'hE1, 8); put(32'h7FF, 5);
    for (int k = 0; k < wn; k++) send_bit(wb[k]);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pid_valid", 32'(rx_packet_pid_valid), 32'(0));
    check("midrst_addr", 32'(rx_packet_addr), 32'(0));
    #1 rst_n = 1'b1;
    // Finish while idle is ignored
    @(posedge clk);
    #1 rx_finish = 1'b1;
    @(posedge clk);
    #1 rx_finish = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_fin_after_reset_or_idle", 32'(fin_count), 32'(fc));

    check("final_pkt_queue", 32'(exp_pkts.size()), 32'(0));
    check("final_byte_queue", 32'(exp_bytes.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
